// File: rtl/byte_enabled_sdp_ram_fwd.sv
// rtl/byte_enabled_sdp_ram_fwd.sv - byte-enabled simple dual-port RAM with
// per-lane read-during-write forwarding, 1/2-cycle read pipeline and post-reset clear.
module byte_enabled_sdp_ram_fwd #(
  parameter int A              = 6,
  parameter int N              = 4,
  parameter int B              = 8,
  parameter int RD_LATENCY     = 1,
  parameter int FORWARD        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [A-1:0]     waddr,
  input  logic [N-1:0]     be,
  input  logic [N*B-1:0]   wdata,
  input  logic             re,
  input  logic [A-1:0]     raddr,
  output logic [N*B-1:0]   q,
  output logic             q_valid,
  output logic             init_done
);

  localparam int W = N * B;
  localparam int D = 1 << A;

  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("RD_LATENCY must be 1 or 2");
    end
    if (N < 1) begin : g_bad_lanes
      $error("N must be at least 1");
    end
  endgenerate

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t           r_state;
  logic [A-1:0]     r_cnt;
  logic             r_init_done;
  logic [W-1:0]     r_mem [D];
  logic [W-1:0]     r_q;
  logic             r_q_valid;
  logic             w_ready;
  logic             w_accept;
  logic [W-1:0]     w_rdata;

  assign w_ready  = (r_state == S_READY);
  assign w_accept = w_ready && re;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
      r_cnt       <= '0;
      r_init_done <= (CLEAR_ON_RESET == 0);
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {A{1'b1}}) begin
            r_state     <= S_READY;
            r_init_done <= 1'b1;
          end
        end
        default: r_state <= S_READY;
      endcase
    end
  end

  // The array itself is never reset; the clear sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!w_ready) begin
        r_mem[r_cnt] <= '0;
      end else if (we) begin
        for (int i = 0; i < N; i++) begin
          if (be[i]) r_mem[waddr][i*B +: B] <= wdata[i*B +: B];
        end
      end
    end
  end

  always_comb begin
    w_rdata = r_mem[raddr];
    if (FORWARD != 0 && we && waddr == raddr) begin
      for (int i = 0; i < N; i++) begin
        if (be[i]) w_rdata[i*B +: B] = wdata[i*B +: B];
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [W-1:0] r_s1;
      logic         r_s1_valid;
      always_ff @(posedge clk) begin
        if (reset) begin
          r_s1       <= '0;
          r_s1_valid <= 1'b0;
          r_q        <= '0;
          r_q_valid  <= 1'b0;
        end else begin
          r_s1_valid <= w_accept;
          if (w_accept) r_s1 <= w_rdata;
          r_q_valid <= r_s1_valid;
          if (r_s1_valid) r_q <= r_s1;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (reset) begin
          r_q       <= '0;
          r_q_valid <= 1'b0;
        end else begin
          r_q_valid <= w_accept;
          if (w_accept) r_q <= w_rdata;
        end
      end
    end
  endgenerate

  assign q         = r_q;
  assign q_valid   = r_q_valid;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_byte_enabled_sdp_ram_fwd.sv
// tb/tb_byte_enabled_sdp_ram_fwd.sv - bench for byte_enabled_sdp_ram_fwd; instance a is
// RD_LATENCY=2/FORWARD=1, instance b is RD_LATENCY=1/FORWARD=0, both on shared stimulus.
module tb_byte_enabled_sdp_ram_fwd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  waddr = '0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        re = 1'b0;
  logic [3:0]  raddr = '0;
  logic [31:0] qa, qb;
  logic        qa_v, qb_v, ida, idb;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem_m [16];
  int          since = 0;
  logic        pa_v = 1'b0;
  logic [31:0] pa_d = '0;
  logic [31:0] ea_q = '0, eb_q = '0;
  logic        ea_v = 1'b0, eb_v = 1'b0;
  int          edge_n = 0;

  always #5 clk = ~clk;

  byte_enabled_sdp_ram_fwd #(.A(4), .N(4), .B(8), .RD_LATENCY(2), .FORWARD(1), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .be(be), .wdata(wdata),
    .re(re), .raddr(raddr), .q(qa), .q_valid(qa_v), .init_done(ida));

  byte_enabled_sdp_ram_fwd #(.A(4), .N(4), .B(8), .RD_LATENCY(1), .FORWARD(0), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .be(be), .wdata(wdata),
    .re(re), .raddr(raddr), .q(qb), .q_valid(qb_v), .init_done(idb));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive, model the edge from the behavioural rules, compare both instances.
  task automatic step(input logic rst, input logic we_i, input logic [3:0] wa, input logic [3:0] be_i,
                      input logic [31:0] wd, input logic re_i, input logic [3:0] ra);
    logic [31:0] old_w, new_w;
    @(negedge clk);
    reset = rst; we = we_i; waddr = wa; be = be_i; wdata = wd; re = re_i; raddr = ra;
    @(posedge clk);
    edge_n++;
    if (rst) begin
      since = 0; pa_v = 1'b0; ea_q = '0; ea_v = 1'b0; eb_q = '0; eb_v = 1'b0;
    end else begin
      ea_v = pa_v;
      if (pa_v) ea_q = pa_d;
      pa_v = 1'b0;
      eb_v = 1'b0;
      if (since >= 16) begin
        if (re_i) begin
          old_w = mem_m[ra];
          new_w = old_w;
          if (we_i && wa == ra)
            for (int i = 0; i < 4; i++) if (be_i[i]) new_w[i*8 +: 8] = wd[i*8 +: 8];
          pa_v = 1'b1; pa_d = new_w;
          eb_v = 1'b1; eb_q = old_w;
        end
        if (we_i)
          for (int i = 0; i < 4; i++) if (be_i[i]) mem_m[wa][i*8 +: 8] = wd[i*8 +: 8];
      end else begin
        since++;
        if (since == 16) for (int k = 0; k < 16; k++) mem_m[k] = '0;
      end
    end
    #1;
    chk($sformatf("a_valid@%0d", edge_n), {31'b0, qa_v}, {31'b0, ea_v});
    chk($sformatf("a_q@%0d", edge_n), qa, ea_q);
    chk($sformatf("a_init@%0d", edge_n), {31'b0, ida}, {31'b0, since >= 16});
    chk($sformatf("b_valid@%0d", edge_n), {31'b0, qb_v}, {31'b0, eb_v});
    chk($sformatf("b_q@%0d", edge_n), qb, eb_q);
    chk($sformatf("b_init@%0d", edge_n), {31'b0, idb}, {31'b0, since >= 16});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
  endtask

  typedef struct {
    logic        we; logic [3:0] wa; logic [3:0] be; logic [31:0] wd;
    logic        re; logic [3:0] ra;
    logic        ca; logic [31:0] xa;
    logic        cb; logic [31:0] xb;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int cyc;
    logic [31:0] sv [8];

    tbl[0] = '{1'b1, 4'd5, 4'hF, 32'hAABBCCDD, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 4'd5, 4'h5, 32'h11223344, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd5, 1'b0, 32'h0, 1'b1, 32'hAA22CC44};
    tbl[3] = '{1'b1, 4'd9, 4'hF, 32'h01020304, 1'b0, 4'd0, 1'b1, 32'hAA22CC44, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 4'd9, 4'h8, 32'hFF000000, 1'b1, 4'd9, 1'b0, 32'h0, 1'b1, 32'h01020304};
    tbl[5] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd9, 1'b1, 32'hFF020304, 1'b1, 32'hFF020304};
    tbl[6] = '{1'b1, 4'd5, 4'h0, 32'h0,        1'b0, 4'd0, 1'b1, 32'hFF020304, 1'b0, 32'h0};
    tbl[7] = '{1'b1, 4'd2, 4'hF, 32'h12345678, 1'b1, 4'd5, 1'b0, 32'h0, 1'b1, 32'hAA22CC44};
    tbl[8] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b1, 4'd2, 1'b1, 32'hAA22CC44, 1'b1, 32'h12345678};
    tbl[9] = '{1'b0, 4'd0, 4'h0, 32'h0,        1'b0, 4'd0, 1'b1, 32'h12345678, 1'b0, 32'h0};

    step(1'b1, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);

    // Clear with traffic driven that must be ignored.
    cyc = 0;
    do begin
      step(1'b0, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF, 1'b1, 4'd3);
      cyc++;
    end while (!ida && cyc < 40);
    chk("clear_length", cyc, 32'd16);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(i));
      if (i == 3) begin
        chk("addr3_after_clear_valid", {31'b0, qb_v}, 32'd1);
        chk("addr3_after_clear_q", qb, 32'd0);
      end
    end
    idle(); idle();

    for (int r = 0; r < 10; r++) begin
      step(1'b0, tbl[r].we, tbl[r].wa, tbl[r].be, tbl[r].wd, tbl[r].re, tbl[r].ra);
      if (tbl[r].ca) begin
        chk($sformatf("tbl%0d_a_valid", r), {31'b0, qa_v}, 32'd1);
        chk($sformatf("tbl%0d_a_q", r), qa, tbl[r].xa);
      end
      if (tbl[r].cb) begin
        chk($sformatf("tbl%0d_b_valid", r), {31'b0, qb_v}, 32'd1);
        chk($sformatf("tbl%0d_b_q", r), qb, tbl[r].xb);
      end
    end

    // Streaming reads over addresses 0..7 on the 2-cycle instance.
    for (int i = 0; i < 8; i++) begin
      sv[i] = 32'h5A000000 + i * 32'h00010203;
      step(1'b0, 1'b1, 4'(i), 4'hF, sv[i], 1'b0, 4'd0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(i));
      if (i == 0) chk("stream_first_not_valid", {31'b0, qa_v}, 32'd0);
      else begin
        chk($sformatf("stream%0d_valid", i - 1), {31'b0, qa_v}, 32'd1);
        chk($sformatf("stream%0d_q", i - 1), qa, sv[i-1]);
      end
    end
    idle();
    chk("stream7_valid", {31'b0, qa_v}, 32'd1);
    chk("stream7_q", qa, sv[7]);
    idle();
    chk("stream_end_valid", {31'b0, qa_v}, 32'd0);
    chk("stream_end_frozen_q", qa, sv[7]);

    // Reset with a read in flight, then reset again partway through the clear.
    step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd2);
    step(1'b1, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
    chk("rst_inflight_a_q", qa, 32'd0);
    chk("rst_inflight_a_valid", {31'b0, qa_v}, 32'd0);
    for (int i = 0; i < 7; i++) idle();
    chk("mid_clear_init_low", {31'b0, ida}, 32'd0);
    step(1'b1, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
    cyc = 0;
    do begin
      idle();
      cyc++;
    end while (!ida && cyc < 40);
    chk("reclear_length", cyc, 32'd16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(i));
      chk($sformatf("reclear_addr%0d", i), qb, 32'd0);
    end
    idle(); idle();

    for (int n = 0; n < 400; n++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    idle(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
